// File: rtl/caravel_nes_pkg.sv
// Shared types and constants for the dual NES controller reader.
package caravel_nes_pkg;

    localparam int unsigned NES_BITS   = 8;
    localparam int unsigned PCNT_W     = $clog2(NES_BITS);

    // Button positions within a pressed vector (bit7 is shifted in first).
    localparam int unsigned BTN_A      = 7;
    localparam int unsigned BTN_B      = 6;
    localparam int unsigned BTN_SELECT = 5;
    localparam int unsigned BTN_START  = 4;
    localparam int unsigned BTN_UP     = 3;
    localparam int unsigned BTN_DOWN   = 2;
    localparam int unsigned BTN_LEFT   = 1;
    localparam int unsigned BTN_RIGHT  = 0;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LATCH_HI = 3'd1,
        ST_LATCH_LO = 3'd2,
        ST_PULSE_HI = 3'd3,
        ST_PULSE_LO = 3'd4,
        ST_DONE     = 3'd5
    } nes_state_e;

    typedef struct packed {
        logic [NES_BITS-1:0] p1;
        logic [NES_BITS-1:0] p2;
    } nes_buttons_t;

    // Controller lines are active-low; game logic wants 1 = pressed.
    function automatic logic [NES_BITS-1:0] nes_pressed(input logic [NES_BITS-1:0] raw);
        return ~raw;
    endfunction

endpackage

// File: rtl/nes_shift_rx.sv
// Per-player serial capture: shifts one data bit in on each sample strobe.
// Build option NES_INPUT_SYNC_EN adds a two-flop synchronizer on data_i.
module nes_shift_rx
    import caravel_nes_pkg::*;
(
    input  logic                clk,
    input  logic                nrst,
    input  logic                sample_i,
    input  logic                data_i,
    output logic [NES_BITS-1:0] shift_o
);

    logic                data_s;
    logic [NES_BITS-1:0] shift_q, shift_d;

`ifdef NES_INPUT_SYNC_EN
    logic [1:0] sync_q;

    // Resets to the released level so a cold line never reads as pressed.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], data_i};
        end
    end

    assign data_s = sync_q[1];
`else
    assign data_s = data_i;
`endif

    always_comb begin
        shift_d = shift_q;
        if (sample_i) begin
            shift_d = {shift_q[NES_BITS-2:0], data_s};
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            shift_q <= '1;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign shift_o = shift_q;

endmodule

// File: rtl/caravel_nes_reader.sv
// Dual NES controller reader: periodic latch + 8 pulses, publishes pressed vectors.
// Build option NES_INPUT_SYNC_EN synchronizes the serial data inputs.
module caravel_nes_reader
    import caravel_nes_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = 100,
    parameter int unsigned POLL_CYCLES = 666_666
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                en,
    input  logic                p1_data,
    input  logic                p2_data,
    output logic                nes_latch,
    output logic                nes_pulse,
    output logic [NES_BITS-1:0] p1_buttons,
    output logic [NES_BITS-1:0] p2_buttons,
    output logic                valid
);

    localparam int unsigned TW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int unsigned PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [TW-1:0]     PHASE_LAST = TW'(HALF_PERIOD - 1);
    localparam logic [PW-1:0]     POLL_LAST  = PW'(POLL_CYCLES - 1);
    localparam logic [PCNT_W-1:0] PULSE_LAST = PCNT_W'(NES_BITS - 1);

    nes_state_e          state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [PW-1:0]       poll_q, poll_d;
    logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
    logic                latch_q, latch_d;
    logic                pulse_q, pulse_d;
    logic                valid_q, valid_d;
    nes_buttons_t        btn_q, btn_d;
    logic                sample_c;
    logic                phase_end_c;
    logic [NES_BITS-1:0] shift1, shift2;

    assign phase_end_c = (timer_q == PHASE_LAST);

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q + TW'(1);
        poll_d   = (poll_q == POLL_LAST) ? '0 : poll_q + PW'(1);
        pcnt_d   = pcnt_q;
        btn_d    = btn_q;
        valid_d  = 1'b0;
        sample_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (poll_q == POLL_LAST) begin
                    state_d = ST_LATCH_HI;
                end
            end
            ST_LATCH_HI: begin
                if (phase_end_c) begin
                    timer_d = '0;
                    state_d = ST_LATCH_LO;
                end
            end
            ST_LATCH_LO: begin
                if (phase_end_c) begin
                    timer_d  = '0;
                    sample_c = 1'b1;
                    pcnt_d   = '0;
                    state_d  = ST_PULSE_HI;
                end
            end
            ST_PULSE_HI: begin
                if (phase_end_c) begin
                    timer_d = '0;
                    state_d = ST_PULSE_LO;
                end
            end
            ST_PULSE_LO: begin
                // The eighth pulse is a dummy: only seven bits remain after the latch sample.
                if (phase_end_c) begin
                    timer_d  = '0;
                    sample_c = (pcnt_q != PULSE_LAST);
                    pcnt_d   = pcnt_q + PCNT_W'(1);
                    state_d  = (pcnt_q == PULSE_LAST) ? ST_DONE : ST_PULSE_HI;
                end
            end
            ST_DONE: begin
                timer_d  = '0;
                btn_d.p1 = nes_pressed(shift1);
                btn_d.p2 = nes_pressed(shift2);
                valid_d  = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                timer_d = '0;
                state_d = ST_IDLE;
            end
        endcase

        // Disable aborts any partial frame; published vectors are kept.
        if (!en) begin
            state_d  = ST_IDLE;
            timer_d  = '0;
            poll_d   = '0;
            btn_d    = btn_q;
            valid_d  = 1'b0;
            sample_c = 1'b0;
        end

        latch_d = (state_d == ST_LATCH_HI);
        pulse_d = (state_d == ST_PULSE_HI);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            poll_q  <= '0;
            pcnt_q  <= '0;
            latch_q <= 1'b0;
            pulse_q <= 1'b0;
            valid_q <= 1'b0;
            btn_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            poll_q  <= poll_d;
            pcnt_q  <= pcnt_d;
            latch_q <= latch_d;
            pulse_q <= pulse_d;
            valid_q <= valid_d;
            btn_q   <= btn_d;
        end
    end

    nes_shift_rx u_rx_p1 (
        .clk      (clk),
        .nrst     (nrst),
        .sample_i (sample_c),
        .data_i   (p1_data),
        .shift_o  (shift1)
    );

    nes_shift_rx u_rx_p2 (
        .clk      (clk),
        .nrst     (nrst),
        .sample_i (sample_c),
        .data_i   (p2_data),
        .shift_o  (shift2)
    );

    assign nes_latch  = latch_q;
    assign nes_pulse  = pulse_q;
    assign p1_buttons = btn_q.p1;
    assign p2_buttons = btn_q.p2;
    assign valid      = valid_q;

endmodule

// File: tb/tb_caravel_nes_reader.sv
// Self-checking bench for caravel_nes_reader with a behavioural NES controller model.
module tb_caravel_nes_reader;

    localparam int HALF = 4;
    localparam int POLL = 200;
    localparam int NVEC = 10;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       en = 1'b0;
    wire        p1_data;
    wire        p2_data;
    logic       nes_latch;
    logic       nes_pulse;
    logic [7:0] p1_buttons;
    logic [7:0] p2_buttons;
    logic       valid;

    always #5 clk = ~clk;

    caravel_nes_reader #(
        .HALF_PERIOD (HALF),
        .POLL_CYCLES (POLL)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .en         (en),
        .p1_data    (p1_data),
        .p2_data    (p2_data),
        .nes_latch  (nes_latch),
        .nes_pulse  (nes_pulse),
        .p1_buttons (p1_buttons),
        .p2_buttons (p2_buttons),
        .valid      (valid)
    );

    // Controller model: latch rise presents bit7, each pulse rise presents the next bit.
    logic [7:0] pat1 = 8'hFF;
    logic [7:0] pat2 = 8'hFF;
    logic       stuck_en = 1'b0;
    logic       stuck_val = 1'b1;
    int         idx = 8;

    function automatic logic ctrl_bit(input logic [7:0] pat, input int i);
        if (i < 0 || i > 7) return 1'b1;
        return pat[7-i];
    endfunction

    always @(posedge nes_latch or posedge nes_pulse) begin
        if (nes_latch) idx = 0;
        else           idx = idx + 1;
    end

    assign p1_data = stuck_en ? stuck_val : ctrl_bit(pat1, idx);
    assign p2_data = stuck_en ? stuck_val : ctrl_bit(pat2, idx);

    // Line monitor: edge counts, phase widths, valid strobes and latency.
    int         cyc = 0;
    int         latch_rises = 0;
    int         pulse_rises = 0;
    int         valid_cnt = 0;
    int         shape_bad = 0;
    int         lat_run = 0;
    int         pul_run = 0;
    int         latch_rise_cyc = 0;
    int         last_pulse_cyc = 0;
    int         latency = 0;
    logic       first_pulse = 1'b0;
    logic       latch_p = 1'b0;
    logic       pulse_p = 1'b0;
    logic [7:0] cap1 = 8'h00;
    logic [7:0] cap2 = 8'h00;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (nes_latch && !latch_p) begin
            latch_rises    = latch_rises + 1;
            latch_rise_cyc = cyc;
            first_pulse    = 1'b1;
        end
        if (nes_latch) lat_run = lat_run + 1;
        else begin
            if (latch_p && lat_run != HALF) shape_bad = shape_bad + 1;
            lat_run = 0;
        end
        if (nes_pulse && !pulse_p) begin
            pulse_rises = pulse_rises + 1;
            if (first_pulse) begin
                if (cyc - latch_rise_cyc != 2*HALF) shape_bad = shape_bad + 1;
                first_pulse = 1'b0;
            end else if (cyc - last_pulse_cyc != 2*HALF) begin
                shape_bad = shape_bad + 1;
            end
            last_pulse_cyc = cyc;
        end
        if (nes_pulse) pul_run = pul_run + 1;
        else begin
            if (pulse_p && pul_run != HALF) shape_bad = shape_bad + 1;
            pul_run = 0;
        end
        if (valid) begin
            valid_cnt = valid_cnt + 1;
            cap1      = p1_buttons;
            cap2      = p2_buttons;
            latency   = cyc - latch_rise_cyc;
        end
        latch_p = nes_latch;
        pulse_p = nes_pulse;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int got, input int exp);
        checks = checks + 1;
        if (got != exp) begin
            errors = errors + 1;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Reference: a line reading 0 is a pressed button, first bit lands in bit7.
    function automatic logic [7:0] model_read(input logic [7:0] line_bits);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[7-k] = (line_bits[7-k] == 1'b0);
        return r;
    endfunction

    task automatic do_frame(input logic [7:0] e1, input logic [7:0] e2, input string name);
        int v0, l0, p0, b0, n;
        v0 = valid_cnt; l0 = latch_rises; p0 = pulse_rises; b0 = shape_bad; n = 0;
        while (valid_cnt == v0 && n < POLL + 20*HALF + 50) begin
            step();
            n++;
        end
        check({name, "_valid_seen"}, int'(valid_cnt != v0), 1);
        repeat (3) step();
        check({name, "_valid_once"}, valid_cnt - v0, 1);
        check({name, "_latches"}, latch_rises - l0, 1);
        check({name, "_pulses"}, pulse_rises - p0, 8);
        check({name, "_shape"}, shape_bad - b0, 0);
        check({name, "_latency"}, latency, 18*HALF + 1);
        check({name, "_p1"}, int'(cap1), int'(e1));
        check({name, "_p2"}, int'(cap2), int'(e2));
        check({name, "_p1_hold"}, int'(p1_buttons), int'(e1));
    endtask

    typedef struct {
        logic [7:0] p1;
        logic [7:0] p2;
        logic       stk;
        logic       stk_val;
        logic [7:0] e1;
        logic [7:0] e2;
        string      name;
    } vec_t;

    vec_t tv[NVEC];

    initial begin
        int n, v0, l0, p0;

        tv[0] = '{8'hEF, 8'hFF, 1'b0, 1'b1, 8'h10, 8'h00, "start"};
        tv[1] = '{8'hFD, 8'hFF, 1'b0, 1'b1, 8'h02, 8'h00, "left_a"};
        tv[2] = '{8'hFD, 8'hFF, 1'b0, 1'b1, 8'h02, 8'h00, "left_b"};
        tv[3] = '{8'h5A, 8'hA5, 1'b0, 1'b1, 8'hA5, 8'h5A, "post_abort"};
        tv[4] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 8'hFF, "stuck0"};
        tv[5] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 8'h00, "stuck1"};
        for (int i = 6; i < NVEC; i++) begin
            tv[i].p1      = 8'($urandom);
            tv[i].p2      = 8'($urandom);
            tv[i].stk     = 1'b0;
            tv[i].stk_val = 1'b1;
            tv[i].e1      = model_read(tv[i].p1);
            tv[i].e2      = model_read(tv[i].p2);
            tv[i].name    = $sformatf("rand%0d", i);
        end

        // Reset state.
        repeat (3) step();
        check("rst_latch", int'(nes_latch), 0);
        check("rst_pulse", int'(nes_pulse), 0);
        check("rst_p1", int'(p1_buttons), 0);
        check("rst_p2", int'(p2_buttons), 0);
        check("rst_valid", int'(valid), 0);

        // First poll arrives POLL_CYCLES clocks after enable.
        pat1 = 8'hEF;
        pat2 = 8'hFF;
        @(negedge clk);
        en   = 1'b1;
        nrst = 1'b1;
        n = 0;
        while (!nes_latch && n < POLL + 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("first_latch_delay", n, POLL);
        v0 = valid_cnt;
        n  = 0;
        while (valid_cnt == v0 && n < 30*HALF) begin
            step();
            n++;
        end
        check("first_valid_seen", int'(valid_cnt != v0), 1);
        check("first_p1", int'(cap1), 8'h10);
        check("first_p2", int'(cap2), 8'h00);

        for (int i = 0; i < 3; i++) begin
            pat1 = tv[i].p1; pat2 = tv[i].p2;
            stuck_en = tv[i].stk; stuck_val = tv[i].stk_val;
            do_frame(tv[i].e1, tv[i].e2, tv[i].name);
        end

        // Abort while the fifth pulse is high.
        pat1 = 8'h00;
        v0 = valid_cnt; l0 = latch_rises; p0 = pulse_rises; n = 0;
        while (pulse_rises < p0 + 5 && n < POLL + 30*HALF) begin
            step();
            n++;
        end
        check("abort_reached_pulse", int'(nes_pulse), 1);
        en = 1'b0;
        step();
        check("abort_latch_low", int'(nes_latch), 0);
        check("abort_pulse_low", int'(nes_pulse), 0);
        l0 = latch_rises;
        repeat (POLL + 20) step();
        check("abort_no_valid", valid_cnt - v0, 0);
        check("abort_no_poll", latch_rises - l0, 0);
        check("abort_p1_kept", int'(p1_buttons), 8'h02);
        check("abort_p2_kept", int'(p2_buttons), 8'h00);
        en = 1'b1;

        for (int i = 3; i < NVEC; i++) begin
            pat1 = tv[i].p1; pat2 = tv[i].p2;
            stuck_en = tv[i].stk; stuck_val = tv[i].stk_val;
            do_frame(tv[i].e1, tv[i].e2, tv[i].name);
        end

        // Asynchronous reset in the middle of a frame.
        pat1 = 8'h3C; pat2 = 8'hC3;
        stuck_en = 1'b0;
        n = 0;
        while (!nes_pulse && n < POLL + 30*HALF) begin
            step();
            n++;
        end
        check("midrst_in_frame", int'(nes_pulse), 1);
        nrst = 1'b0;
        #1;
        check("midrst_pulse", int'(nes_pulse), 0);
        check("midrst_latch", int'(nes_latch), 0);
        check("midrst_p1", int'(p1_buttons), 0);
        check("midrst_p2", int'(p2_buttons), 0);
        check("midrst_valid", int'(valid), 0);
        repeat (2) step();
        nrst = 1'b1;
        repeat (2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
